// File: rtl/disp_pkg.sv
// disp_pkg: encodings shared by the OLED screen sequencer and the pixel mux.
//   ST_*   : 2-bit screen-select codes (00 = title/VT screen, others = element/battle)
//   PIX_W  : pixel index width seen by the mux
package disp_pkg;

  localparam logic [1:0] ST_TITLE     = 2'b00;
  localparam logic [1:0] ST_COUNTDOWN = 2'b01;
  localparam logic [1:0] ST_BATTLE    = 2'b10;
  localparam logic [1:0] ST_RESULT    = 2'b11;

  localparam int unsigned PIX_W = 16;

  typedef enum logic [1:0] {
    S_TITLE     = ST_TITLE,
    S_COUNTDOWN = ST_COUNTDOWN,
    S_BATTLE    = ST_BATTLE,
    S_RESULT    = ST_RESULT
  } disp_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect: 1-bit rising-edge detector with a registered history bit.
//   clk, reset : clock and synchronous active-high reset (history cleared)
//   d          : level input
//   rise       : high in the cycle d is 1 and was 0 on the previous clock
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  // Combinational output so an edge can be applied in the cycle it arrives.
  assign rise = d & ~d_q;

endmodule

// File: rtl/disp_state_ctrl.sv
// disp_state_ctrl: frame-synchronous screen sequencer (title -> countdown ->
// battle -> result -> title). Screen changes only on frame_begin.
//   clk, reset     : clock, synchronous active-high reset
//   frame_begin    : one-cycle pulse at pixel index 0 of each frame
//   btn_start      : debounced start button (level)
//   game_over      : one-cycle pulse from the battle logic
//   winner         : battle winner, sampled with game_over
//   state          : screen select for the pixel mux
//   countdown      : digit 3/2/1 during countdown, 0 otherwise
//   result_winner  : latched winner shown on the result screen
//   battle_active  : enables the game logic while in battle
module disp_state_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned CD_FRAMES     = 1017,
  parameter int unsigned RESULT_FRAMES = 3051
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_begin,
  input  logic       btn_start,
  input  logic       game_over,
  input  logic       winner,
  output logic [1:0] state,
  output logic [1:0] countdown,
  output logic       result_winner,
  output logic       battle_active
);

  localparam int unsigned CNT_MAX = max_u(CD_FRAMES, RESULT_FRAMES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CD_LIM  = CNT_W'(CD_FRAMES);
  localparam logic [CNT_W-1:0] RES_LIM = CNT_W'(RESULT_FRAMES);

  disp_state_e      st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       cd_q, cd_d;
  logic             pend_start_q, pend_start_d;
  logic             pend_over_q, pend_over_d;
  logic             pend_title_q, pend_title_d;
  logic             win_q, win_d;
  logic             battle_q;
  logic             btn_rise;

  rise_detect u_btn_rise (
    .clk   (clk),
    .reset (reset),
    .d     (btn_start),
    .rise  (btn_rise)
  );

  // Saturating increment: the counter never wraps.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // Pending flags are set first and then tested, so a request arriving in
  // the frame_begin cycle is applied in that same cycle.
  always_comb begin
    st_d         = st_q;
    cnt_d        = cnt_q;
    cd_d         = cd_q;
    pend_start_d = pend_start_q;
    pend_over_d  = pend_over_q;
    pend_title_d = pend_title_q;
    win_d        = win_q;

    unique case (st_q)
      S_TITLE: begin
        if (btn_rise) pend_start_d = 1'b1;
        if (frame_begin && pend_start_d) begin
          st_d  = S_COUNTDOWN;
          cd_d  = 2'd3;
          cnt_d = '0;
        end
      end
      S_COUNTDOWN: begin
        if (frame_begin) begin
          if (cnt_inc >= CD_LIM) begin
            cnt_d = '0;
            if (cd_q == 2'd1) begin
              st_d = S_BATTLE;
              cd_d = 2'd0;
            end else begin
              cd_d = cd_q - 2'd1;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_BATTLE: begin
        // Only the first game_over latches the winner.
        if (game_over && !pend_over_q) begin
          pend_over_d = 1'b1;
          win_d       = winner;
        end
        if (frame_begin && pend_over_d) begin
          st_d  = S_RESULT;
          cnt_d = '0;
        end
      end
      S_RESULT: begin
        if (btn_rise) pend_title_d = 1'b1;
        if (frame_begin) begin
          if (pend_title_d || cnt_inc >= RES_LIM) begin
            st_d  = S_TITLE;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: st_d = S_TITLE;
    endcase

    if (st_d != st_q) begin
      pend_start_d = 1'b0;
      pend_over_d  = 1'b0;
      pend_title_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q         <= S_TITLE;
      cnt_q        <= '0;
      cd_q         <= 2'd0;
      pend_start_q <= 1'b0;
      pend_over_q  <= 1'b0;
      pend_title_q <= 1'b0;
      win_q        <= 1'b0;
      battle_q     <= 1'b0;
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      cd_q         <= cd_d;
      pend_start_q <= pend_start_d;
      pend_over_q  <= pend_over_d;
      pend_title_q <= pend_title_d;
      win_q        <= win_d;
      battle_q     <= (st_d == S_BATTLE);
    end
  end

  assign state         = st_q;
  assign countdown     = cd_q;
  assign result_winner = win_q;
  assign battle_active = battle_q;

endmodule
